// File: rtl/pixel_stream_out.sv
// pixel_stream_out: serialises a static pixel array (indices 0..SIZE) into a
// one-pixel-per-beat valid/ready stream with a last-beat marker and a
// one-cycle done pulse after the final transfer.
// Optional: define PIX_CHECKSUM_EN to add a 16-bit wrap-around frame checksum.
module pixel_stream_out #(
    parameter int SIZE   = 100,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rgb_value [SIZE:0],
    input  logic              start,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last,
    output logic [ADDR_W-1:0] pix_index,
    output logic              busy,
    output logic              done
`ifdef PIX_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SIZE);

    // The index register must be able to hold SIZE.
    generate
        if ((SIZE >> ADDR_W) != 0) begin : g_addr_chk
            $error("pixel_stream_out: ADDR_W too narrow for SIZE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              xfer;
    logic              at_last;
    logic [ADDR_W-1:0] idx_nxt;
    logic [7:0]        data_nxt;

    assign xfer     = pix_valid && pix_ready;
    assign at_last  = (pix_index == LAST_IDX);
    assign idx_nxt  = pix_index + 1'b1;
    assign pix_last = pix_valid && at_last;

    // Select the pixel following the current one; a compare-mux keeps the
    // index width independent of the array depth.
    always_comb begin
        data_nxt = 8'h00;
        for (int i = 0; i <= SIZE; i++) begin
            if (idx_nxt == ADDR_W'(i)) data_nxt = rgb_value[i];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: start only matters in IDLE; DONE lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = STREAM;
            STREAM:  if (xfer && at_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered stream outputs; valid is held until the beat is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_data  <= 8'h00;
            pix_valid <= 1'b0;
            pix_index <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pix_data  <= rgb_value[0];
                        pix_index <= '0;
                        pix_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (at_last) begin
                            pix_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            pix_index <= idx_nxt;
                            pix_data  <= data_nxt;
                        end
                    end
                end
                DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    pix_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIX_CHECKSUM_EN
    // Frame checksum: cleared on accepted start, accumulates each transfer.
    always_ff @(posedge clk) begin
        if (rst)                        checksum <= 16'h0000;
        else if (state == IDLE && start) checksum <= 16'h0000;
        else if (state == STREAM && xfer) checksum <= checksum + 16'(pix_data);
    end
`endif

endmodule

// File: tb/tb_pixel_stream_out.sv
// Directed bench for pixel_stream_out: three instances (SIZE=3, SIZE=0,
// SIZE=300). Inputs change 1 time unit after each rising edge and outputs
// are checked at the same point, so each step() advances exactly one cycle.
module tb_pixel_stream_out;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    // Instance A: SIZE=3
    logic [7:0]  rgb_a [3:0];
    logic        start_a = 1'b0, ready_a = 1'b0;
    logic [7:0]  data_a;
    logic        valid_a, last_a, busy_a, done_a;
    logic [15:0] idx_a;

    // Instance B: SIZE=0
    logic [7:0]  rgb_b [0:0];
    logic        start_b = 1'b0, ready_b = 1'b0;
    logic [7:0]  data_b;
    logic        valid_b, last_b, busy_b, done_b;
    logic [15:0] idx_b;

    // Instance C: SIZE=300
    logic [7:0]  rgb_c [300:0];
    logic        start_c = 1'b0, ready_c = 1'b0;
    logic [7:0]  data_c;
    logic        valid_c, last_c, busy_c, done_c;
    logic [15:0] idx_c;
`ifdef PIX_CHECKSUM_EN
    logic [15:0] cks_a, cks_b, cks_c;
`endif

    pixel_stream_out #(.SIZE(3), .ADDR_W(16)) u_a (
        .clk(clk), .rst(rst), .rgb_value(rgb_a), .start(start_a),
        .pix_data(data_a), .pix_valid(valid_a), .pix_ready(ready_a),
        .pix_last(last_a), .pix_index(idx_a), .busy(busy_a), .done(done_a)
`ifdef PIX_CHECKSUM_EN
        , .checksum(cks_a)
`endif
    );

    pixel_stream_out #(.SIZE(0), .ADDR_W(16)) u_b (
        .clk(clk), .rst(rst), .rgb_value(rgb_b), .start(start_b),
        .pix_data(data_b), .pix_valid(valid_b), .pix_ready(ready_b),
        .pix_last(last_b), .pix_index(idx_b), .busy(busy_b), .done(done_b)
`ifdef PIX_CHECKSUM_EN
        , .checksum(cks_b)
`endif
    );

    pixel_stream_out #(.SIZE(300), .ADDR_W(16)) u_c (
        .clk(clk), .rst(rst), .rgb_value(rgb_c), .start(start_c),
        .pix_data(data_c), .pix_valid(valid_c), .pix_ready(ready_c),
        .pix_last(last_c), .pix_index(idx_c), .busy(busy_c), .done(done_c)
`ifdef PIX_CHECKSUM_EN
        , .checksum(cks_c)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks one beat of instance A.
    task automatic chk_beat_a(input string tag, input int i, input logic [7:0] d);
        chk({tag, "_valid"}, 32'(valid_a), 32'd1);
        chk({tag, "_data"},  32'(data_a), 32'(d));
        chk({tag, "_index"}, 32'(idx_a), 32'(i));
        chk({tag, "_last"},  32'(last_a), (i == 3) ? 32'd1 : 32'd0);
        chk({tag, "_busy"},  32'(busy_a), 32'd1);
        chk({tag, "_done"},  32'(done_a), 32'd0);
    endtask

    logic [7:0] exp_a [4];
    int         pat   [7];
    int         xi;

    initial begin
        exp_a = '{8'h10, 8'h20, 8'h30, 8'h40};
        for (int i = 0; i < 4; i++) rgb_a[i] = exp_a[i];
        rgb_b[0] = 8'hAB;
        for (int i = 0; i <= 300; i++) rgb_c[i] = 8'hFF;

        // Reset state
        step(); step();
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_busy",  32'(busy_a), 32'd0);
        chk("rst_done",  32'(done_a), 32'd0);
        chk("rst_index", 32'(idx_a), 32'd0);
        chk("rst_data",  32'(data_a), 32'd0);
        chk("rst_last",  32'(last_a), 32'd0);
        rst = 1'b0;
        step();

        // 1. Basic frame, sink always ready
        start_a = 1'b1; ready_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_beat_a("basic", i, exp_a[i]);
            step();
        end
        chk("basic_done",      32'(done_a), 32'd1);
        chk("basic_done_vld",  32'(valid_a), 32'd0);
        chk("basic_done_busy", 32'(busy_a), 32'd0);
        step();
        chk("basic_done_off",  32'(done_a), 32'd0);

        // 2. Backpressure: ready pattern 1,0,0,1,0,1,1 over cycles 1..7
        pat = '{1, 0, 0, 1, 0, 1, 1};
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        xi = 0;
        for (int c = 0; c < 7; c++) begin
            ready_a = pat[c][0];
            chk_beat_a("bp", xi, exp_a[xi]);
            if (pat[c] == 1) xi++;
            step();
        end
        chk("bp_done",     32'(done_a), 32'd1);
        chk("bp_done_vld", 32'(valid_a), 32'd0);
        ready_a = 1'b1;
        step();
        chk("bp_done_off", 32'(done_a), 32'd0);

        // 3. start reasserted during STREAM and DONE is ignored
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start_a = (i == 1);
            chk_beat_a("rs", i, exp_a[i]);
            step();
        end
        start_a = 1'b1;                   // held through the DONE cycle
        chk("rs_done", 32'(done_a), 32'd1);
        step();
        start_a = 1'b0;
        chk("rs_idle_vld",  32'(valid_a), 32'd0);
        chk("rs_idle_busy", 32'(busy_a), 32'd0);
        chk("rs_idle_done", 32'(done_a), 32'd0);
        step();
        chk("rs_idle2_busy", 32'(busy_a), 32'd0);
        chk("rs_idle2_done", 32'(done_a), 32'd0);

        // 4. Reset after two transfers
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        step(); step();
        chk_beat_a("mr_pre", 2, 8'h30);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_vld",   32'(valid_a), 32'd0);
        chk("mr_busy",  32'(busy_a), 32'd0);
        chk("mr_index", 32'(idx_a), 32'd0);
        chk("mr_data",  32'(data_a), 32'd0);
        for (int c = 0; c < 3; c++) begin
            chk("mr_nodone", 32'(done_a), 32'd0);
            step();
        end
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_beat_a("mr_new", i, exp_a[i]);
            step();
        end
        chk("mr_new_done", 32'(done_a), 32'd1);
        step();

        // 5. SIZE=0: single last beat then done
        start_b = 1'b1; ready_b = 1'b1;
        step();
        start_b = 1'b0;
        chk("s0_valid", 32'(valid_b), 32'd1);
        chk("s0_data",  32'(data_b), 32'hAB);
        chk("s0_last",  32'(last_b), 32'd1);
        chk("s0_index", 32'(idx_b), 32'd0);
        chk("s0_busy",  32'(busy_b), 32'd1);
        step();
        chk("s0_done",     32'(done_b), 32'd1);
        chk("s0_done_vld", 32'(valid_b), 32'd0);
        chk("s0_done_lst", 32'(last_b), 32'd0);
        step();
        chk("s0_done_off", 32'(done_b), 32'd0);

        // 6. SIZE=300, all 0xFF, two frames back to back
        for (int f = 0; f < 2; f++) begin
            start_c = 1'b1; ready_c = 1'b1;
            step();
            start_c = 1'b0;
`ifdef PIX_CHECKSUM_EN
            chk("big_cks_clr", 32'(cks_c), 32'd0);
`endif
            chk("big_first_idx", 32'(idx_c), 32'd0);
            for (int i = 0; i <= 300; i++) begin
                if (i == 300) begin
                    chk("big_last",     32'(last_c), 32'd1);
                    chk("big_last_idx", 32'(idx_c), 32'd300);
                    chk("big_last_dat", 32'(data_c), 32'hFF);
                end
                step();
            end
            chk("big_done", 32'(done_c), 32'd1);
            chk("big_busy", 32'(busy_c), 32'd0);
`ifdef PIX_CHECKSUM_EN
            chk("big_cks", 32'(cks_c), 32'h2BD3);
`endif
            step();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
